// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one i2c_top master between N_REQ requesters
// and sequences a single load/enable/wait/release transfer per grant.
module i2c_req_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned TIMEOUT   = 4096,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 i2c_core_clk_i,
  input  logic                 i2c_rst_ni,
  input  logic [N_REQ-1:0]     req_i,
  input  logic [8*N_REQ-1:0]   addr_rw_i,
  input  logic [8*N_REQ-1:0]   wdata_i,
  input  logic [7:0]           prescale_i,
  output logic [N_REQ-1:0]     gnt_o,
  output logic [N_REQ-1:0]     done_o,
  output logic [N_REQ-1:0]     err_o,
  output logic [7:0]           rdata_o,
  output logic [7:0]           i2c_data_transmit_o,
  output logic [7:0]           i2c_slave_addr_rw_o,
  output logic [7:0]           i2c_command_o,
  output logic [7:0]           i2c_prescale_o,
  input  logic                 i2c_interrupt_i,
  input  logic [7:0]           i2c_data_receive_i,
  input  logic [7:0]           i2c_status_i
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0] CMD_RESET  = 8'h00;
  localparam logic [7:0] CMD_IDLE   = 8'h80;
  localparam logic [7:0] CMD_ENABLE = 8'hC0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_LOAD,
    S_START,
    S_BUSY,
    S_DONE,
    S_ABORT,
    S_ABORT2
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic [N_REQ-1:0]     done_q, done_d;
  logic [N_REQ-1:0]     err_q, err_d;
  logic [7:0]           rdata_q, rdata_d;
  logic [7:0]           addr_q, addr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [7:0]           presc_q;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 irq_q;

  logic                 irq_rise;
  logic                 sel_found;
  logic [IDX_W-1:0]     sel_idx;
  logic [IDX_W-1:0]     ptr_next;
  logic                 unused_status;
  int unsigned          k;

  assign irq_rise      = i2c_interrupt_i & ~irq_q;
  assign unused_status = ^{i2c_status_i[7:2], i2c_status_i[0]};

  // Pointer after the current owner, wrapping modulo N_REQ.
  assign ptr_next = (32'(gidx_q) == N_REQ - 1) ? '0 : gidx_q + IDX_W'(1);

  // First requester at or after the pointer, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    k         = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = 32'(ptr_q) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (!sel_found && req_i[IDX_W'(k)]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(k);
      end
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    done_d  = '0;
    err_d   = '0;
    cmd_d   = CMD_IDLE;

    case (state_q)
      S_IDLE: begin
        if (|req_i) state_d = S_ARB;
      end
      S_ARB: begin
        if (sel_found) begin
          state_d = S_LOAD;
          gidx_d  = sel_idx;
          gnt_d   = N_REQ'(1) << sel_idx;
          addr_d  = addr_rw_i[{sel_idx, 3'b000} +: 8];
          wdata_d = wdata_i[{sel_idx, 3'b000} +: 8];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (!i2c_status_i[1]) state_d = S_START;
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        cnt_d = cnt_q + TIMEOUT_W'(1);
        if (irq_rise) begin
          state_d = S_DONE;
          rdata_d = i2c_data_receive_i;
          done_d  = gnt_q;
        end else if (cnt_q == TIMEOUT_W'(TIMEOUT - 1)) begin
          state_d = S_ABORT;
          err_d   = gnt_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        ptr_d   = ptr_next;
      end
      S_ABORT: begin
        state_d = S_ABORT2;
      end
      S_ABORT2: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        ptr_d   = ptr_next;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase

    // Command reflects the state being entered so it is valid in that state.
    case (state_d)
      S_START, S_BUSY:   cmd_d = CMD_ENABLE;
      S_ABORT, S_ABORT2: cmd_d = CMD_RESET;
      default:           cmd_d = CMD_IDLE;
    endcase
  end

  always_ff @(posedge i2c_core_clk_i or negedge i2c_rst_ni) begin
    if (!i2c_rst_ni) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cmd_q   <= CMD_RESET;
      presc_q <= '0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cmd_q   <= cmd_d;
      presc_q <= prescale_i;
      cnt_q   <= cnt_d;
      irq_q   <= i2c_interrupt_i;
    end
  end

  assign gnt_o               = gnt_q;
  assign done_o              = done_q;
  assign err_o               = err_q;
  assign rdata_o             = rdata_q;
  assign i2c_data_transmit_o = wdata_q;
  assign i2c_slave_addr_rw_o = addr_q;
  assign i2c_command_o       = cmd_q;
  assign i2c_prescale_o      = presc_q;

endmodule
